// File: rtl/tqvp_rejunity_vga_banked.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_rejunity_vga_banked
// Purpose  : Double-banked multi-bpp line-buffer VGA peripheral for TinyQV.
//            Optional line-compare interrupt: define VGA_BANKED_LINE_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_rejunity_vga_banked #(
  parameter int PIXELS   = 128,
  parameter int BPP      = 2,
  parameter int PIX_CLKS = 8,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int c_bank_bits = PIXELS * BPP;
  localparam int c_words     = c_bank_bits / 32;
  localparam int c_ncol      = 1 << BPP;
  localparam int c_idx_w     = $clog2(PIXELS);
  localparam int c_sub_w     = (PIX_CLKS > 1) ? $clog2(PIX_CLKS) : 1;

  localparam logic [10:0] c_h_last   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_hs_first = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_last  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0]  c_vs_first = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_vs_last  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(PIXELS - 1);
  localparam logic [c_sub_w-1:0] c_sub_last = c_sub_w'(PIX_CLKS - 1);
  localparam logic [23:0] c_pal_rst = {6'h0C, 6'h30, 6'h3F, 6'h00};

  logic [10:0]            r_x;
  logic [9:0]             r_y;
  logic [c_sub_w-1:0]     r_sub;
  logic [c_idx_w-1:0]     r_idx;
  logic [c_bank_bits-1:0] r_bank [2];
  logic [5:0]             r_pal [c_ncol];
  logic                   r_disp, r_swap, r_irq_en, r_irq;
  logic [7:0]             r_uo;

  logic                   w_wbank, w_wr, w_wr32, w_ctl_wr, w_clr, w_vblank;
  logic                   w_line_hit, w_irq_set, w_vis, w_hs, w_vs;
  logic [c_bank_bits-1:0] w_shift;
  logic [BPP-1:0]         w_pix;
  logic [5:0]             w_rgb;
  logic [31:0]            w_rd_word, w_rd_3d, w_rd_3e;
  logic                   w_unused;

  assign w_wbank   = ~r_disp;
  assign w_wr      = (data_write_n != 2'b11);
  assign w_wr32    = (data_write_n == 2'b10);
  assign w_ctl_wr  = w_wr && (address == 6'h3C);
  assign w_clr     = w_wr && (address == 6'h3D);
  assign w_vblank  = (r_x == '0) && (r_y == c_v_active);
  assign w_irq_set = r_irq_en && (w_vblank || w_line_hit);
  assign w_unused  = &{1'b0, ui_in, data_read_n};

  // Counters and the pixel walker restart together so index == x / PIX_CLKS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sub <= '0;
      r_idx <= '0;
    end else if (r_x == c_h_last) begin
      r_x   <= '0;
      r_y   <= (r_y == c_v_last) ? 10'd0 : r_y + 10'd1;
      r_sub <= '0;
      r_idx <= '0;
    end else begin
      r_x <= r_x + 11'd1;
      if (r_sub == c_sub_last) begin
        r_sub <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_sub <= r_sub + c_sub_w'(1);
      end
    end
  end

  assign w_shift = r_bank[r_disp] >> (r_idx * BPP);
  assign w_pix   = w_shift[BPP-1:0];
  assign w_vis   = (r_x < c_h_active) && (r_y < c_v_active);
  assign w_rgb   = w_vis ? r_pal[w_pix] : 6'd0;
  assign w_hs    = !((r_x >= c_hs_first) && (r_x <= c_hs_last));
  assign w_vs    = !((r_y >= c_vs_first) && (r_y <= c_vs_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo     <= 8'b1000_1000;
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      for (int i = 0; i < c_ncol; i++) r_pal[i] <= c_pal_rst[i*6 +: 6];
      r_disp   <= 1'b0;
      r_swap   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_uo <= {w_hs, w_rgb[5:3], w_vs, w_rgb[2:0]};
      for (int w = 0; w < c_words; w++)
        if (w_wr32 && !address[5] && (address[4:2] == 3'(w)))
          r_bank[w_wbank][w*32 +: 32] <= data_in;
      for (int i = 0; i < c_ncol; i++)
        if (w_wr && (address == 6'(48 + i))) r_pal[i] <= data_in[5:0];
      // A request landing on the swap clock survives into the next frame.
      r_disp <= r_disp ^ (w_vblank & r_swap);
      r_swap <= (w_ctl_wr & data_in[0]) | (r_swap & ~w_vblank);
      if (w_ctl_wr) r_irq_en <= data_in[1];
      r_irq <= w_irq_set | (r_irq & ~w_clr);
    end
  end

`ifdef VGA_BANKED_LINE_IRQ_EN
  logic [9:0] r_line_cmp;
  logic       r_cause;

  assign w_line_hit = (r_x == '0) && (r_y == r_line_cmp);
  assign w_rd_3d    = {30'd0, r_cause, r_irq};
  assign w_rd_3e    = {22'd0, r_line_cmp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cmp <= 10'h3FF;
      r_cause    <= 1'b0;
    end else begin
      if (w_wr && (address == 6'h3E)) r_line_cmp <= data_in[9:0];
      if (w_irq_set) r_cause <= w_line_hit;
    end
  end
`else
  assign w_line_hit = 1'b0;
  assign w_rd_3d    = {31'd0, r_irq};
  assign w_rd_3e    = 32'd0;
`endif

  always_comb begin
    w_rd_word = '0;
    for (int w = 0; w < c_words; w++)
      if (address[4:2] == 3'(w)) w_rd_word = r_bank[w_wbank][w*32 +: 32];
  end

  always_comb begin
    data_out = '0;
    if (!address[5]) begin
      data_out = w_rd_word;
    end else begin
      case (address)
        6'h3C:   data_out = {16'd0, r_y, 3'd0, r_swap, r_irq_en, r_disp};
        6'h3D:   data_out = w_rd_3d;
        6'h3E:   data_out = w_rd_3e;
        default: data_out = '0;
      endcase
    end
  end

  assign uo_out         = r_uo;
  assign data_ready     = 1'b1;
  assign user_interrupt = r_irq;

endmodule
`default_nettype wire
